// File: rtl/doppler_sweep_ctrl.sv
// rtl/doppler_sweep_ctrl.sv - Doppler bin sweep sequencer for the acquisition frequency shifter
// Walks the symmetric bin list 0, +1, -1, ... +-N, gating dwell_len samples per bin.
module doppler_sweep_ctrl #(
  parameter int CODE_WIDTH = 32,
  parameter int BIN_W      = 8,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 2,
  parameter int FLUSH_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CODE_WIDTH-1:0] code_step,
  input  logic [BIN_W-1:0]      n_bins,
  input  logic [DWELL_W-1:0]    dwell_len,
  input  logic                  sample_valid,
  input  logic                  fs_valid,
  input  logic                  bin_ack,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_up,
  output logic                  we,
  output logic [BIN_W:0]        bin_idx,
  output logic                  bin_done,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int CNT_MAX = (SETTLE_CYC > FLUSH_CYC) ? SETTLE_CYC : FLUSH_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_FLUSH,
    S_WAIT_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DWELL_W-1:0]    smp_q, smp_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [BIN_W-1:0]      nbins_q, nbins_d;
  logic [CODE_WIDTH-1:0] step_q, step_d;
  logic [CODE_WIDTH-1:0] mag_q, mag_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  code_up_q, code_up_d;
  logic [BIN_W:0]        bin_idx_q, bin_idx_d;
  logic                  bin_done_q, bin_done_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [BIN_W:0]        nxt_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      smp_q      <= '0;
      dwell_q    <= '0;
      nbins_q    <= '0;
      step_q     <= '0;
      mag_q      <= '0;
      code_q     <= '0;
      code_up_q  <= 1'b0;
      bin_idx_q  <= '0;
      bin_done_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      dwell_q    <= dwell_d;
      nbins_q    <= nbins_d;
      step_q     <= step_d;
      mag_q      <= mag_d;
      code_q     <= code_d;
      code_up_q  <= code_up_d;
      bin_idx_q  <= bin_idx_d;
      bin_done_q <= bin_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    smp_d      = smp_q;
    dwell_d    = dwell_q;
    nbins_d    = nbins_q;
    step_d     = step_q;
    mag_d      = mag_q;
    code_d     = code_q;
    code_up_d  = code_up_q;
    bin_idx_d  = bin_idx_q;
    bin_done_d = bin_done_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    we         = 1'b0;
    nxt_idx    = bin_idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dwell_d   = (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
          nbins_d   = n_bins;
          step_d    = code_step;
          mag_d     = code_step;
          code_d    = '0;
          code_up_d = 1'b1;
          bin_idx_d = '0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          smp_d     = '0;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (sample_valid) begin
          we = 1'b1;
          if (smp_q == dwell_q - DWELL_W'(1)) begin
            smp_d = '0;
            cnt_d = '0;
            if (FLUSH_CYC == 0) begin
              bin_done_d = 1'b1;
              state_d    = S_WAIT_ACK;
            end else begin
              state_d = S_FLUSH;
            end
          end else begin
            smp_d = smp_q + DWELL_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
          cnt_d      = '0;
          bin_done_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (bin_ack) begin
          bin_done_d = 1'b0;
          if (bin_idx_q == {nbins_q, 1'b0}) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // Odd bins take +mag; the following even bin takes -mag and advances it.
            bin_idx_d = nxt_idx;
            code_d    = mag_q;
            if (nxt_idx[0]) begin
              code_up_d = 1'b1;
            end else begin
              code_up_d = 1'b0;
              mag_d     = mag_q + step_q;
            end
            state_d = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, but the code and bin number stay where they were.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      we         = 1'b0;
      cnt_d      = '0;
      smp_d      = '0;
      mag_d      = mag_q;
      code_d     = code_q;
      code_up_d  = code_up_q;
      bin_idx_d  = bin_idx_q;
      bin_done_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      aborted_d  = 1'b1;
    end
  end

  assign code     = code_q;
  assign code_up  = code_up_q;
  assign bin_idx  = bin_idx_q;
  assign bin_done = bin_done_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

  flush_quiet_a: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_FLUSH && cnt_q == CNT_W'(FLUSH_CYC - 1)) |-> !fs_valid);

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// tb/tb_doppler_sweep_ctrl.sv - self-checking bench for doppler_sweep_ctrl
module tb_doppler_sweep_ctrl;
  localparam int CW = 32;
  localparam int BW = 8;
  localparam int DW = 16;
  localparam int SC = 2;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          resetn, start, abort, sample_valid, fs_valid, bin_ack;
  logic [CW-1:0] code_step;
  logic [BW-1:0] n_bins;
  logic [DW-1:0] dwell_len;
  logic [CW-1:0] code;
  logic          code_up, we, bin_done, busy, done, aborted;
  logic [BW:0]   bin_idx;

  always #5 clk = ~clk;

  doppler_sweep_ctrl #(
    .CODE_WIDTH(CW), .BIN_W(BW), .DWELL_W(DW), .SETTLE_CYC(SC), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .code_step(code_step), .n_bins(n_bins), .dwell_len(dwell_len),
    .sample_valid(sample_valid), .fs_valid(fs_valid), .bin_ack(bin_ack),
    .code(code), .code_up(code_up), .we(we), .bin_idx(bin_idx),
    .bin_done(bin_done), .busy(busy), .done(done), .aborted(aborted)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [CW-1:0] code;
    logic          up;
    logic [BW:0]   idx;
  } bin_t;

  typedef struct {
    int            n;
    logic [CW-1:0] step;
    int            dwell;
    int            mode;
    int            delay;
    int            poke;
    int            exp_we;
  } vec_t;

  bin_t exp_q[$];
  bin_t cur;
  bit   mon_en = 1'b0;
  bit   sv_const;
  bit   hold_bad;
  logic prev_bd;
  int   sv_mode = 2;
  int   we_cnt, we_total, exp_dwell, ref_cyc, ack_cyc, last_we_cyc, done_cnt, bins_seen;

  // Sample source: 0 = always valid, 1 = valid every other cycle, 2 = driven by hand.
  initial begin
    sample_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sv_mode)
        0:       sample_valid = 1'b1;
        1:       sample_valid = ~sample_valid;
        default: ;
      endcase
    end
  end

  // Shifter model: valid comes back one cycle after each accepted sample.
  logic we_seen;
  initial begin
    fs_valid = 1'b0;
    forever begin
      @(negedge clk);
      we_seen = we;
      @(posedge clk);
      #1;
      fs_valid = (we_seen === 1'b1);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (we) begin
        chk("we_needs_valid", sample_valid, 1);
        chk("we_not_waiting", bin_done, 0);
        chk("we_while_busy", busy, 1);
        we_cnt++;
        we_total++;
        if (we_cnt == 1) begin
          if (sv_const) chk("first_we_cycle", cyc, ref_cyc + 1 + SC);
          else          chk("first_we_min", cyc >= ref_cyc + 1 + SC, 1);
        end
        last_we_cyc = cyc;
      end
      if (bin_done && !prev_bd) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("bin_code", code, cur.code);
          chk("bin_code_up", code_up, cur.up);
          chk("bin_idx", bin_idx, cur.idx);
        end
        chk("we_per_bin", we_cnt, exp_dwell);
        chk("bin_done_cycle", cyc, last_we_cyc + 1 + FC);
        we_cnt = 0;
        hold_bad = 1'b0;
        bins_seen++;
      end
      if (bin_done && code !== cur.code) hold_bad = 1'b1;
      if (!bin_done && prev_bd) begin
        chk("bin_done_fall", cyc, ack_cyc + 1);
        chk("code_hold", hold_bad, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, ack_cyc + 1);
        chk("busy_at_done", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
      end
      prev_bd = bin_done;
    end
  end

  task automatic run_sweep(input vec_t v);
    logic [CW-1:0] k;
    bin_t b;
    int w;
    exp_q.delete();
    for (int i = 0; i <= 2 * v.n; i++) begin
      k     = CW'((i + 1) / 2);
      b.code = k * v.step;
      b.up   = (i == 0) ? 1'b1 : ((i % 2) == 1);
      b.idx  = (BW + 1)'(i);
      exp_q.push_back(b);
    end
    exp_dwell = (v.dwell == 0) ? 1 : v.dwell;
    sv_mode   = v.mode;
    sv_const  = (v.mode == 0);
    we_cnt = 0; we_total = 0; done_cnt = 0; bins_seen = 0;
    prev_bd = 1'b0; hold_bad = 1'b0;
    cur.code = '0; cur.up = 1'b0; cur.idx = '0;
    @(posedge clk); #1;
    n_bins = BW'(v.n); code_step = v.step; dwell_len = DW'(v.dwell);
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; ref_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_code", code, 0);
    chk("start_code_up", code_up, 1);
    chk("start_bin_idx", bin_idx, 0);
    if (v.poke != 0) begin
      n_bins = 8'd5; code_step = 32'h999; dwell_len = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int bn = 0; bn <= 2 * v.n; bn++) begin
      w = 0;
      while (!bin_done && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      chk("bin_done_timeout", bin_done, 1);
      if (!bin_done) break;
      for (int d = 0; d < v.delay; d++) begin
        @(posedge clk); #1;
      end
      bin_ack = 1'b1; ack_cyc = cyc; ref_cyc = cyc;
      @(posedge clk); #1;
      bin_ack = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("bins_seen", bins_seen, 2 * v.n + 1);
    chk("we_total", we_total, v.exp_we);
    mon_en = 1'b0;
    sv_mode = 2;
    sample_valid = 1'b0;
  endtask

  vec_t vecs[6];
  int   wcnt;
  int   w;

  initial begin
    vecs[0] = '{2, 32'h1000,      4, 0, 0,  0, 20};
    vecs[1] = '{2, 32'h1000,      4, 1, 0,  0, 20};
    vecs[2] = '{2, 32'h1000,      4, 0, 10, 0, 20};
    vecs[3] = '{0, 32'h0,         0, 0, 0,  0, 1};
    vecs[4] = '{3, 32'h4000_0000, 1, 1, 2,  0, 7};
    vecs[5] = '{1, 32'h100,       2, 0, 0,  1, 6};

    resetn = 1'b0; start = 1'b0; abort = 1'b0; bin_ack = 1'b0;
    code_step = '0; n_bins = '0; dwell_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", code, 0);
    chk("rst_code_up", code_up, 0);
    chk("rst_we", we, 0);
    chk("rst_bin_idx", bin_idx, 0);
    chk("rst_bin_done", bin_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // Abort in the third dwell cycle of bin 1.
    sv_mode = 0;
    n_bins = 8'd2; code_step = 32'h1000; dwell_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!bin_done && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("abort_bin0_done", bin_done, 1);
    bin_ack = 1'b1;
    @(posedge clk); #1;
    bin_ack = 1'b0;
    wcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (we) wcnt++;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_we_gated", we, 0);
    chk("abort_we_before", wcnt, 2);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_bin_done", bin_done, 0);
    chk("abort_no_done", done, 0);
    chk("abort_code_kept", code, 32'h1000);
    chk("abort_up_kept", code_up, 1);
    chk("abort_idx_kept", bin_idx, 1);
    @(posedge clk); #1;
    chk("abort_pulse_end", aborted, 0);
    sv_mode = 2;
    sample_valid = 1'b0;
    run_sweep(vecs[0]);

    // start together with abort while idle does nothing.
    sv_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_aborted", aborted, 0);
    wcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (we) wcnt++;
    end
    chk("sa_no_we", wcnt, 0);
    chk("sa_busy_later", busy, 0);

    // Asynchronous reset in the middle of bin 1's dwell.
    n_bins = 8'd1; code_step = 32'h300; dwell_len = 16'd8;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!bin_done && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_bin0_done", bin_done, 1);
    bin_ack = 1'b1;
    @(posedge clk); #1;
    bin_ack = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!we && w < 50);
    chk("rst_seq_we_seen", we, 1);
    chk("rst_seq_code_pre", code, 32'h300);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_code", code, 0);
    chk("arst_code_up", code_up, 0);
    chk("arst_we", we, 0);
    chk("arst_bin_idx", bin_idx, 0);
    chk("arst_bin_done", bin_done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_aborted", aborted, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (we) wcnt++;
    end
    chk("arst_no_we_after", wcnt, 0);
    chk("arst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/doppler_sweep_ctrl.md
# doppler_sweep_ctrl

Sequencer for the acquisition front-end frequency shifter. It steps the shifter's 32-bit DDS phase-increment code and direction flag through a symmetric Doppler bin list (0, +1, −1, +2, −2, … ±N steps). For each bin it gates exactly dwell_len input samples into the shifter, then holds until the downstream correlator acknowledges the bin. It sits between the acquisition register block (configuration, start/abort) and the freq_shift datapath (code, code_up, we, valid).

## Interface
- CODE_WIDTH, 32: width of the DDS phase-increment code.
- BIN_W, 8: width of the bin count per side and of bin_idx (bin_idx is BIN_W+1 bits).
- DWELL_W, 16: width of the dwell sample counter.
- SETTLE_CYC, 2: idle cycles after a code change before samples are gated (DDS settle); must be ≥1.
- FLUSH_CYC, 2: cycles after the last gated sample before bin_done (shifter output register plus valid).

- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- abort  in  1  terminate the sweep; effective in any state
- code_step  in  CODE_WIDTH  code increment per Doppler bin; latched on start
- n_bins  in  BIN_W  bins per side N; total bins 2N+1; latched on start
- dwell_len  in  DWELL_W  samples per bin; 0 is treated as 1; latched on start
- sample_valid  in  1  input sample strobe from the ADC path
- fs_valid  in  1  freq_shift valid return, used for the flush check
- bin_ack  in  1  correlator has dumped the bin result
- code  out  CODE_WIDTH  DDS code magnitude to freq_shift
- code_up  out  1  1 = positive Doppler, 0 = negative
- we  out  1  sample enable to freq_shift
- bin_idx  out  BIN_W+1  sequential bin number, 0..2N
- bin_done  out  1  level; bin finished, awaiting bin_ack
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse; sweep completed normally
- aborted  out  1  one-cycle pulse; sweep terminated by abort

## Operation
- States: IDLE, SETTLE, DWELL, FLUSH, WAIT_ACK.
- IDLE + start (and abort low):
  - latch the configuration;
  - code←0, code_up←1, bin_idx←0, mag←code_step, busy←1;
  - go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to DWELL.
- DWELL:
  - we = sample_valid (combinational, gated by the state);
  - the sample counter increments on each we;
  - on the we that completes dwell_len samples, go to FLUSH. No further we is issued.
- FLUSH:
  - count FLUSH_CYC cycles, then go to WAIT_ACK with bin_done=1;
  - fs_valid must be 0 in the last FLUSH cycle, otherwise the protocol is broken (assertion).
- WAIT_ACK:
  - hold bin_done until bin_ack; bin_ack in the first WAIT_ACK cycle is honoured;
  - on ack with bin_idx=2N: done pulse, busy←0, go to IDLE;
  - on ack otherwise: bin_idx++, apply the next code (below), go to SETTLE.
- Bin ordering:
  - odd bin_idx: code←mag, code_up←1;
  - even nonzero bin_idx: code←mag, code_up←0, then mag←mag+code_step.
- Arithmetic: mag is CODE_WIDTH bits and wraps mod 2^CODE_WIDTH without saturation. Configuring N·code_step ≥ 2^CODE_WIDTH is illegal.
- abort:
  - in any non-IDLE state, go to IDLE next cycle: we forced 0 in the abort cycle, bin_done←0, busy←0, aborted pulse, no done;
  - code, code_up and bin_idx keep their last values.
- Priorities:
  - abort beats bin_ack and beats start;
  - start while busy is ignored;
  - bin_ack outside WAIT_ACK is ignored.
- n_bins=0: a single zero bin, then done.

## Timing
- Reset values: code=0, code_up=0, we=0, bin_idx=0, bin_done=0, busy=0, done=0, aborted=0; state IDLE.
- Start sampled at cycle t:
  - busy, code and code_up are valid at t+1;
  - the first cycle in which we may be high is t+1+SETTLE_CYC.
- Last we at cycle d: bin_done rises at d+1+FLUSH_CYC.
- bin_ack at cycle a:
  - bin_done falls at a+1;
  - the new code is applied at a+1;
  - the next we is possible at a+1+SETTLE_CYC;
  - on the last bin, done pulses at a+1 and busy falls at a+1.
- All outputs except we are registered.

## Test plan
- N=2, step=0x1000, dwell=4, sample_valid constant 1, bin_ack on the first bin_done cycle → code/code_up sequence 0/1, 0x1000/1, 0x1000/0, 0x2000/1, 0x2000/0; exactly 4 we per bin; bin_idx 0..4; a single done pulse; busy low afterwards.
- Same configuration, sample_valid toggling every other cycle → exactly 4 we per bin; each we coincides with sample_valid; no we during SETTLE, FLUSH or WAIT_ACK.
- bin_ack delayed 10 cycles → bin_done held 10 cycles; code unchanged until ack+1; no we while waiting.
- abort during the 3rd DWELL cycle of bin 1 → we=0 from that cycle; aborted pulse at +1; busy=0; no done; a following start runs a full sweep from bin 0.
- N=0, dwell=0 → one bin with code=0 and exactly 1 we; done at ack+1. start while busy → ignored; start+abort together in IDLE → stays in IDLE.
- Assert resetn mid-DWELL → all outputs return to reset values immediately (asynchronous); no we after reset.
